// File: rtl/pipe_stage_reg_hs.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble and a saturating back-pressure counter.
module pipe_stage_reg_hs #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter int                 DATA_W    = 32,
    parameter int                 NUM_DATA  = 2,
    parameter int                 FLAG_W    = 1,
    parameter int                 CNT_W     = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [FLAG_W-1:0]          in_flag,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [FLAG_W-1:0]          out_flag,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Main register M (drives the outputs)
    logic                       m_valid_q, m_valid_d;
    logic [INSTR_W-1:0]         m_instr_q, m_instr_d;
    logic [PC_W-1:0]            m_pc_q,    m_pc_d;
    logic [NUM_DATA*DATA_W-1:0] m_data_q,  m_data_d;
    logic [FLAG_W-1:0]          m_flag_q,  m_flag_d;

    // Skid register S (one spare beat)
    logic                       s_valid_q, s_valid_d;
    logic [INSTR_W-1:0]         s_instr_q, s_instr_d;
    logic [PC_W-1:0]            s_pc_q,    s_pc_d;
    logic [NUM_DATA*DATA_W-1:0] s_data_q,  s_data_d;
    logic [FLAG_W-1:0]          s_flag_q,  s_flag_d;

    logic                       in_ready_q, in_ready_d;
    logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = m_valid_q & out_ready;

    always_comb begin
        m_valid_d   = m_valid_q;
        m_instr_d   = m_instr_q;
        m_pc_d      = m_pc_q;
        m_data_d    = m_data_q;
        m_flag_d    = m_flag_q;
        s_valid_d   = s_valid_q;
        s_instr_d   = s_instr_q;
        s_pc_d      = s_pc_q;
        s_data_d    = s_data_q;
        s_flag_d    = s_flag_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            // Payload of M is kept so the bubble still reports the last PC.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q) begin
            if (out_fire) begin
                m_valid_d = 1'b1;
                m_instr_d = s_instr_q;
                m_pc_d    = s_pc_q;
                m_data_d  = s_data_q;
                m_flag_d  = s_flag_q;
                s_valid_d = 1'b0;
            end
        end else if (m_valid_q) begin
            if (in_fire && out_fire) begin
                m_instr_d = in_instr;
                m_pc_d    = in_pc;
                m_data_d  = in_data;
                m_flag_d  = in_flag;
            end else if (in_fire) begin
                s_valid_d = 1'b1;
                s_instr_d = in_instr;
                s_pc_d    = in_pc;
                s_data_d  = in_data;
                s_flag_d  = in_flag;
            end else if (out_fire) begin
                m_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            m_valid_d = 1'b1;
            m_instr_d = in_instr;
            m_pc_d    = in_pc;
            m_data_d  = in_data;
            m_flag_d  = in_flag;
        end

        // Ready is registered from the next skid occupancy, never from out_ready.
        in_ready_d = ~s_valid_d;

        if (m_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_valid_q   <= 1'b0;
            m_instr_q   <= NOP_INSTR;
            m_pc_q      <= '0;
            m_data_q    <= '0;
            m_flag_q    <= '0;
            s_valid_q   <= 1'b0;
            s_instr_q   <= NOP_INSTR;
            s_pc_q      <= '0;
            s_data_q    <= '0;
            s_flag_q    <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_instr_q   <= m_instr_d;
            m_pc_q      <= m_pc_d;
            m_data_q    <= m_data_d;
            m_flag_q    <= m_flag_d;
            s_valid_q   <= s_valid_d;
            s_instr_q   <= s_instr_d;
            s_pc_q      <= s_pc_d;
            s_data_q    <= s_data_d;
            s_flag_q    <= s_flag_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_valid_q;
    assign out_instr = m_valid_q ? m_instr_q : NOP_INSTR;
    assign out_flag  = m_valid_q ? m_flag_q : '0;
    assign out_pc    = m_pc_q;
    assign out_data  = m_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule
